id_ex_pipe: RTL
===============

# id_ex_pipe

ID/EX pipeline boundary for the five-stage RV32I core. It registers the decode-stage control bundle produced by the instruction controller, together with operands, immediate and register indices, into the EX stage. It also owns load-use hazard detection, which stalls PC and IF/ID and injects a bubble into EX. Branch/jump resolution flushes it, and it keeps a saturating count of bubbles for performance debug.

## Interface
- `WIDTH`, 32: datapath width (PC, operands, immediate).
- `CNT_W`, 16: bubble counter width.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_ctrl`  in  ctrl_t  ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, Jal, Jalr from the controller.
- `id_pc`, `id_rd1`, `id_rd2`, `id_imm`  in  WIDTH each  PC, register-file reads, immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_funct3`  in  3; `id_funct7`  in  7  ALU-control fields.
- `flush`  in  1  taken branch/jump resolved in EX; squashes the ID instruction.
- `stall`  out  1  load-use hazard; freezes PC and IF/ID this cycle.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_ctrl`  out  ctrl_t  registered control bundle.
- `ex_pc`, `ex_rd1`, `ex_rd2`, `ex_imm`  out  WIDTH  registered data.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  registered indices (forwarding unit consumes rs1/rs2).
- `ex_funct3`  out  3; `ex_funct7`  out  7.
- `bubble_cnt`  out  CNT_W  bubbles inserted since reset, saturating.

## Operation
- Source-use decode:
  - `uses_rs1` = `id_valid` AND NOT (JAL: `Jal`=1, `Jalr`=0) AND NOT (LUI: `ALUOp`=11, `Jalr`=0).
  - `uses_rs2` = `id_valid` AND (`ALUSrc`=0 OR `MemWrite`=1 OR `Branch`=1).
- Hazard condition `hz`: all of the following hold:
  - `ex_valid`=1 and `ex_ctrl.MemRead`=1;
  - `ex_rd` != 0;
  - (`uses_rs1` and `id_rs1`==`ex_rd`) or (`uses_rs2` and `id_rs2`==`ex_rd`).
- `stall` = `hz` AND NOT `flush`. Flush wins because the ID instruction is discarded anyway.
- Next-state priority at each edge:
  - `flush`: load a bubble.
  - `hz`: load a bubble.
  - Otherwise: load all ID fields, with `ex_valid` <= `id_valid`.
- Bubble: `ex_valid`=0 and every `ex_ctrl` bit = 0. Data fields may hold any value, but the bench requires them to be zero for determinism.
- `bubble_cnt` increments by 1 on each edge that loads a bubble because of `flush` or `hz`. It holds at all-ones; it never wraps.
- A stall lasts exactly one cycle per load. Next cycle the load is in MEM, `ex_valid`=0, so `hz` clears and the held ID instruction advances.

## Timing
- Reset (asynchronous, immediate): `ex_valid`=0, `ex_ctrl`=0, all data/index/funct outputs =0, `bubble_cnt`=0, so `stall`=0.
- First capture happens on the first rising edge after `reset` deasserts.
- Latency: 1 cycle from ID inputs to `ex_*` outputs.
- `stall` is combinational from the `id_*` inputs and the registered `ex_*` state, in the same cycle. It has no path from `stall` to the `id_*` inputs.
- `flush` and `hz` in the same cycle: one bubble, counted once; `stall`=0.
- Reset asserted mid-stall: outputs clear at once, and the stall is abandoned.
- `id_valid`=0 with no hazard: captured as an invalid slot, control forced to 0, not counted.

## Structure
- `pipe_pkg` holds:
  - `ctrl_t` packed struct: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, Jal, Jalr.
  - `CTRL_NOP` constant (all zero).
  - `ALUOP_LUI`=2'b11.
- Sub-module `hazard_detect`: purely combinational. Inputs are the ID indices/ctrl/valid and the EX rd/MemRead/valid; output is `hz`. It is instantiated once; the register and counter logic stays in `id_ex_pipe`.

## Test plan
- Plain flow: `add x3,x1,x2` then `addi x4,x3,5`. Each appears in EX one cycle later with `ex_valid`=1, `stall` never 1, `bubble_cnt`=0.
- Load-use on rs1: `lw x5,0(x1)` in EX, `add x6,x5,x7` in ID gives `stall`=1 for one cycle. Next cycle EX is a bubble (`ex_ctrl`=0), then `add` enters EX; `bubble_cnt`=1.
- False hazards:
  - `lw x0,...` followed by `add x6,x0,x7`: `stall`=0.
  - `lw x5,...` followed by `lui x5,...` or `jal x5,...`: `stall`=0.
  - `lw x5,...` followed by `addi x6,x1,x5`-encoded rs2=5: `stall`=0.
- Store rs2 hazard: `lw x5` followed by `sw x5,0(x2)` gives `stall`=1 for one cycle.
- Flush plus hazard in the same cycle gives `stall`=0, one bubble, `bubble_cnt` +1 exactly.
- Counter and reset:
  - Preload `CNT_W`=4, force 20 flushes: `bubble_cnt` holds 15.
  - Assert `reset` mid-stall: all outputs 0 before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX boundary: the decode control bundle and its encodings.
package pipe_pkg;

  typedef struct packed {
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;
    logic       Jal;
    logic       Jalr;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP  = '0;
  localparam logic [1:0] ALUOP_LUI = 2'b11;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detect: an EX load whose rd feeds a source actually read by ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       id_valid_i,
  input  logic       id_alusrc_i,
  input  logic       id_memwrite_i,
  input  logic       id_branch_i,
  input  logic       id_jal_i,
  input  logic       id_jalr_i,
  input  logic [1:0] id_aluop_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       hz_o
);

  logic uses_rs1, uses_rs2, is_jal, is_lui;

  // JAL and LUI carry garbage in the rs1 field; JALR reuses ALUOp so it is excluded from the LUI test.
  assign is_jal   = id_jal_i & ~id_jalr_i;
  assign is_lui   = (id_aluop_i == ALUOP_LUI) & ~id_jalr_i;
  assign uses_rs1 = id_valid_i & ~is_jal & ~is_lui;
  assign uses_rs2 = id_valid_i & (~id_alusrc_i | id_memwrite_i | id_branch_i);

  assign hz_o = ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0) &
                ((uses_rs1 & (id_rs1_i == ex_rd_i)) | (uses_rs2 & (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush-to-bubble and a saturating bubble counter.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  ctrl_t            id_ctrl,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output ctrl_t            ex_ctrl,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_rd1,
  output logic [WIDTH-1:0] ex_rd2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             hz, load_bub;
  logic             ex_valid_q;
  ctrl_t            ex_ctrl_q;
  logic [WIDTH-1:0] ex_pc_q, ex_rd1_q, ex_rd2_q, ex_imm_q;
  logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [2:0]       ex_funct3_q;
  logic [6:0]       ex_funct7_q;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  hazard_detect u_hazard (
    .id_valid_i    (id_valid),
    .id_alusrc_i   (id_ctrl.ALUSrc),
    .id_memwrite_i (id_ctrl.MemWrite),
    .id_branch_i   (id_ctrl.Branch),
    .id_jal_i      (id_ctrl.Jal),
    .id_jalr_i     (id_ctrl.Jalr),
    .id_aluop_i    (id_ctrl.ALUOp),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .ex_valid_i    (ex_valid_q),
    .ex_memread_i  (ex_ctrl_q.MemRead),
    .ex_rd_i       (ex_rd_q),
    .hz_o          (hz)
  );

  // A flushed ID slot is discarded, so there is nothing to hold.
  assign stall    = hz & ~flush;
  assign load_bub = flush | hz;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bub && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_NOP;
      ex_pc_q      <= '0;
      ex_rd1_q     <= '0;
      ex_rd2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_funct3_q  <= '0;
      ex_funct7_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      if (load_bub) begin
        ex_valid_q  <= 1'b0;
        ex_ctrl_q   <= CTRL_NOP;
        ex_pc_q     <= '0;
        ex_rd1_q    <= '0;
        ex_rd2_q    <= '0;
        ex_imm_q    <= '0;
        ex_rs1_q    <= '0;
        ex_rs2_q    <= '0;
        ex_rd_q     <= '0;
        ex_funct3_q <= '0;
        ex_funct7_q <= '0;
      end else begin
        ex_valid_q  <= id_valid;
        ex_ctrl_q   <= id_valid ? id_ctrl : CTRL_NOP;
        ex_pc_q     <= id_pc;
        ex_rd1_q    <= id_rd1;
        ex_rd2_q    <= id_rd2;
        ex_imm_q    <= id_imm;
        ex_rs1_q    <= id_rs1;
        ex_rs2_q    <= id_rs2;
        ex_rd_q     <= id_rd;
        ex_funct3_q <= id_funct3;
        ex_funct7_q <= id_funct7;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rd1     = ex_rd1_q;
  assign ex_rd2     = ex_rd2_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_funct3  = ex_funct3_q;
  assign ex_funct7  = ex_funct7_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
